// File: rtl/uart_pkg.sv
// Shared encodings and defaults for the UART packet scheduler.
package uart_pkg;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_CSUM} state_e;

  localparam logic [7:0]  HDR_BASE_DEF = 8'hA0;
  localparam int unsigned CSUM_W       = 8;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Producer-side byte streams plus the UART byte handshake, bundled for uart_tx_sched.
interface uart_tx_sched_if #(
  parameter int unsigned NUM_CH = 4
);

  logic [NUM_CH-1:0]   ch_vld;
  logic [NUM_CH*8-1:0] ch_data;
  logic [NUM_CH-1:0]   ch_last;
  logic [NUM_CH-1:0]   ch_rdy;
  logic [7:0]          tx_data;
  logic                tx_vld;
  logic                tx_rdy;

  modport master (
    output ch_vld, ch_data, ch_last, tx_rdy,
    input  ch_rdy, tx_data, tx_vld
  );

  modport slave (
    input  ch_vld, ch_data, ch_last, tx_rdy,
    output ch_rdy, tx_data, tx_vld
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request strictly after ptr, wrapping modulo NUM_CH.
module rr_arbiter #(
  parameter int unsigned NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [3:0]        ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [3:0]        idx
);

  int unsigned cand;

  // Walk from lowest to highest priority so the highest-priority request overwrites last.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    cand = 0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = (int'(ptr) + k) % NUM_CH;
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = 4'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Packet-granular round-robin scheduler framing channel payloads (header, bytes, XOR
// trailer) onto a single UART byte stream.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter logic [7:0]  HDR_BASE = HDR_BASE_DEF,
  parameter bit          TRL_EN   = 1'b1,
  parameter int unsigned MAX_PKT  = 64
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_sched_if.slave    bus,
  output logic              busy,
  output logic [3:0]        grant_id,
  output logic              pkt_done,
  output logic              trunc
);

  localparam int unsigned IW      = $clog2(NUM_CH);
  localparam logic [7:0]  MAX_CNT = 8'(MAX_PKT);

  state_e            state_q, state_d;
  logic [3:0]        rr_q;
  logic [CSUM_W-1:0] csum_q;
  logic [7:0]        cnt_q;
  logic [7:0]        cnt_inc;
  logic              pkt_done_q;
  logic [NUM_CH-1:0] arb_gnt;
  logic [3:0]        arb_idx;
  logic [IW-1:0]     g;
  logic              req_any;
  logic              xfer;
  logic              data_end;
  logic              pkt_end;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req (bus.ch_vld),
    .ptr (rr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign g        = grant_id[IW-1:0];
  assign req_any  = |arb_gnt;
  assign xfer     = bus.tx_vld & bus.tx_rdy;
  assign cnt_inc  = cnt_q + 8'd1;
  assign data_end = (state_q == S_DATA) && xfer && (bus.ch_last[g] || (cnt_inc == MAX_CNT));
  assign pkt_end  = TRL_EN ? ((state_q == S_CSUM) && xfer) : data_end;
  assign trunc    = (state_q == S_DATA) && xfer && !bus.ch_last[g] && (cnt_inc == MAX_CNT);
  assign busy     = (state_q != S_IDLE);
  assign pkt_done = pkt_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (req_any) state_d = S_HDR;
      S_HDR:   if (xfer) state_d = S_DATA;
      S_DATA:  if (data_end) state_d = TRL_EN ? S_CSUM : S_IDLE;
      S_CSUM:  if (xfer) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Payload is not latched: DATA forwards the granted producer straight to the UART.
  always_comb begin
    bus.tx_vld  = 1'b0;
    bus.tx_data = '0;
    bus.ch_rdy  = '0;
    unique case (state_q)
      S_HDR: begin
        bus.tx_vld  = 1'b1;
        bus.tx_data = HDR_BASE + {4'b0000, grant_id};
      end
      S_DATA: begin
        bus.tx_vld    = bus.ch_vld[g];
        bus.tx_data   = bus.ch_data[{g, 3'b000} +: 8];
        bus.ch_rdy[g] = bus.tx_rdy;
      end
      S_CSUM: begin
        bus.tx_vld  = 1'b1;
        bus.tx_data = csum_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q       <= 4'(NUM_CH - 1);
      grant_id   <= '0;
      csum_q     <= '0;
      cnt_q      <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      pkt_done_q <= pkt_end;
      if ((state_q == S_IDLE) && req_any) grant_id <= arb_idx;
      if ((state_q == S_HDR) && xfer) begin
        csum_q <= '0;
        cnt_q  <= '0;
      end
      if ((state_q == S_DATA) && xfer) begin
        csum_q <= csum_q ^ bus.tx_data;
        cnt_q  <= cnt_inc;
      end
      if (pkt_end) rr_q <= grant_id;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomised scoreboard bench for uart_tx_sched: a frame-level round-robin model predicts
// the UART byte stream; a monitor pops and compares on every UART transfer.
module tb_uart_tx_sched;

  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned MAX_PKT = 4;
  localparam logic [7:0]  HDR     = 8'hA0;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [3:0] grant_id;
  logic       pkt_done;
  logic       trunc;

  uart_tx_sched_if #(.NUM_CH(NUM_CH)) bus ();

  uart_tx_sched #(
    .NUM_CH   (NUM_CH),
    .HDR_BASE (HDR),
    .TRL_EN   (1'b1),
    .MAX_PKT  (MAX_PKT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id),
    .pkt_done (pkt_done),
    .trunc    (trunc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         hdr;
    int         ch;
    bit         fin;
    bit         trn;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         sb_en = 1'b0;

  // Producer-side streams and frame-level model state.
  logic [7:0] pdata  [NUM_CH][$];
  bit         plast  [NUM_CH][$];
  bit         pstart [NUM_CH][$];
  logic [7:0] mbytes [NUM_CH][$];
  int         flen   [NUM_CH][$];
  bit         ftrn   [NUM_CH][$];
  int         m_fcnt [NUM_CH];
  int         gap    [NUM_CH];
  int         fix_gap[NUM_CH];
  int         m_rr = NUM_CH - 1;
  bit         gaps_en = 1'b0;
  int         rdy_mode = 0;
  int         stall_left = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic add_byte(input int c, input logic [7:0] b, input bit l);
    pstart[c].push_back(m_fcnt[c] == 0);
    pdata[c].push_back(b);
    plast[c].push_back(l);
    mbytes[c].push_back(b);
    m_fcnt[c]++;
    if (l || m_fcnt[c] == MAX_PKT) begin
      flen[c].push_back(m_fcnt[c]);
      ftrn[c].push_back(!l);
      m_fcnt[c] = 0;
    end
  endtask

  task automatic add_pkt(input int c, input int len);
    for (int i = 0; i < len; i++) add_byte(c, 8'($urandom), i == len - 1);
  endtask

  // Round-robin over channels that still own frames; each frame = header, bytes, XOR.
  task automatic schedule();
    bit more = 1'b1;
    while (more) begin
      int c = -1;
      for (int k = 1; k <= NUM_CH; k++) begin
        int j = (m_rr + k) % NUM_CH;
        if (c < 0 && flen[j].size() > 0) c = j;
      end
      if (c < 0) begin
        more = 1'b0;
      end else begin
        int n;
        bit t;
        logic [7:0] cs = 8'h00;
        exp_t e;
        n = flen[c].pop_front();
        t = ftrn[c].pop_front();
        e = '{data: HDR + 8'(c), hdr: 1'b1, ch: c, fin: 1'b0, trn: 1'b0};
        exp_q.push_back(e);
        for (int i = 0; i < n; i++) begin
          logic [7:0] b = mbytes[c].pop_front();
          cs ^= b;
          e = '{data: b, hdr: 1'b0, ch: c, fin: 1'b0, trn: t && (i == n - 1)};
          exp_q.push_back(e);
        end
        e = '{data: cs, hdr: 1'b0, ch: c, fin: 1'b1, trn: 1'b0};
        exp_q.push_back(e);
        m_rr = c;
      end
    end
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < NUM_CH; i++) if (pdata[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic clear_all();
    exp_q.delete();
    for (int i = 0; i < NUM_CH; i++) begin
      pdata[i].delete(); plast[i].delete(); pstart[i].delete(); mbytes[i].delete();
      flen[i].delete(); ftrn[i].delete();
      m_fcnt[i] = 0; gap[i] = 0; fix_gap[i] = 0;
    end
    bus.ch_vld  = '0;
    bus.ch_last = '0;
  endtask

  // One clock of producer and UART-ready behaviour; returns at posedge + 1.
  task automatic step();
    bit acc[NUM_CH];
    @(negedge clk);
    for (int i = 0; i < NUM_CH; i++) acc[i] = bus.ch_vld[i] && bus.ch_rdy[i];
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (acc[i]) begin
        void'(pdata[i].pop_front());
        void'(plast[i].pop_front());
        void'(pstart[i].pop_front());
        // Gaps only inside a frame so idle-time requests stay visible to arbitration.
        if (pstart[i].size() > 0 && !pstart[i][0]) begin
          if (fix_gap[i] > 0) begin
            gap[i] = fix_gap[i];
            fix_gap[i] = 0;
          end else if (gaps_en && $urandom_range(0, 3) == 0) begin
            gap[i] = $urandom_range(1, 5);
          end
        end
      end else if (gap[i] > 0) begin
        gap[i]--;
      end
      if (pdata[i].size() > 0 && gap[i] == 0) begin
        bus.ch_vld[i]          = 1'b1;
        bus.ch_data[8*i +: 8]  = pdata[i][0];
        bus.ch_last[i]         = plast[i][0];
      end else begin
        bus.ch_vld[i]  = 1'b0;
        bus.ch_last[i] = 1'b0;
      end
    end
    if (stall_left > 0) begin
      stall_left--;
      bus.tx_rdy = 1'b0;
    end else if (rdy_mode == 0) begin
      bus.tx_rdy = 1'b1;
    end else begin
      bus.tx_rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 63) == 0) stall_left = 20;
    end
  endtask

  task automatic recover();
    sb_en = 1'b0;
    clear_all();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_rr = NUM_CH - 1;
    step();
    sb_en = 1'b1;
  endtask

  task automatic run_phase(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || pending()) && n < budget) begin
      step();
      n++;
    end
    repeat (3) step();
    checks++;
    if (exp_q.size() != 0 || pending()) begin
      errors++;
      $display("FAIL %s drain: %0d bytes outstanding, required 0", name, exp_q.size());
      recover();
    end
  endtask

  initial begin : monitor
    logic       pv, pr, pfin, fin, trn_exp, xf;
    logic [7:0] pd;
    exp_t       e;
    pv = 1'b0; pr = 1'b0; pfin = 1'b0; pd = 8'h00;
    forever begin
      @(negedge clk);
      if (sb_en && !rst) begin
        chk("pkt_done", pkt_done, pfin);
        if (pv && !pr) begin
          chk("hold_vld", bus.tx_vld, 1);
          chk("hold_data", bus.tx_data, pd);
        end
        chk("ch_rdy_onehot", $onehot0(bus.ch_rdy), 1);
        if (!bus.tx_rdy) chk("ch_rdy_stalled", bus.ch_rdy, 0);
        xf = bus.tx_vld && bus.tx_rdy;
        fin = 1'b0;
        trn_exp = 1'b0;
        if (xf) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL tx_byte: got unexpected 0x%02h, required no transfer", bus.tx_data);
          end else begin
            e = exp_q.pop_front();
            if (bus.tx_data !== e.data) begin
              errors++;
              $display("FAIL tx_byte: got 0x%02h, required 0x%02h (ch %0d)",
                       bus.tx_data, e.data, e.ch);
            end
            if (e.hdr) chk("grant_id", grant_id, e.ch);
            chk("busy", busy, 1);
            fin = e.fin;
            trn_exp = e.trn;
          end
        end
        chk("trunc", trunc, trn_exp);
        pv = bus.tx_vld; pr = bus.tx_rdy; pd = bus.tx_data; pfin = fin;
      end else begin
        pv = 1'b0;
        pfin = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    bit seen;
    rst = 1'b1;
    bus.ch_vld = '0; bus.ch_data = '0; bus.ch_last = '0; bus.tx_rdy = 1'b1;
    clear_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_vld", bus.tx_vld, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_ch_rdy", bus.ch_rdy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_pkt_done", pkt_done, 0);
    chk("rst_trunc", trunc, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    sb_en = 1'b1;

    // Single packet on ch2: A2 12 34 56 70.
    add_byte(2, 8'h12, 1'b0); add_byte(2, 8'h34, 1'b0); add_byte(2, 8'h56, 1'b1);
    schedule();
    run_phase("single", 200);

    // Contention after reset: ch0, ch1, ch3 with two 1-byte packets each.
    recover();
    for (int p = 0; p < 2; p++) begin
      add_pkt(0, 1); add_pkt(1, 1); add_pkt(3, 1);
    end
    schedule();
    run_phase("contention", 300);

    // Truncation: 6 bytes on ch1 split into 4+csum and 2+csum.
    add_pkt(1, 6);
    schedule();
    run_phase("truncation", 300);

    // Backpressure: 20-cycle UART stall in the middle of a payload.
    add_pkt(3, 3);
    schedule();
    repeat (4) step();
    stall_left = 20;
    run_phase("backpressure", 300);

    // Reset while ch1 is mid-payload; nothing of that packet is checked.
    sb_en = 1'b0;
    add_pkt(1, 4);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (bus.ch_rdy[1]) seen = 1'b1;
    end
    chk("reach_data", seen, 1);
    rst = 1'b1;
    clear_all();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx_vld", bus.tx_vld, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ch_rdy", bus.ch_rdy, 0);
    chk("mid_rst_grant_id", grant_id, 0);
    m_rr = NUM_CH - 1;
    sb_en = 1'b1;

    // Producer gap on ch0 with ch1/ch3 waiting: ch0 first, then ch1, then ch3.
    add_pkt(3, 1); add_pkt(0, 3); add_pkt(1, 2);
    fix_gap[0] = 5;
    schedule();
    run_phase("gap", 300);

    // Randomised traffic with gaps and UART backpressure.
    gaps_en = 1'b1;
    rdy_mode = 1;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        int npk = $urandom_range(0, 2);
        for (int p = 0; p < npk; p++) add_pkt(c, $urandom_range(1, 6));
      end
      schedule();
      run_phase("random", 3000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
